// File: rtl/ysyx_22050518_axi_pkg.sv
// Shared AXI encodings, width constants and FSM state types for the SRAM slave.
// Imported by the slave top and its burst address helper.
package ysyx_22050518_axi_pkg;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_22050518_axi_burst_addr.sv
// Combinational next-beat address and burst legality for one AXI burst.
// Step is 1<<size; WRAP keeps the high bits and wraps within (len+1)*step bytes.
module ysyx_22050518_axi_burst_addr
  import ysyx_22050518_axi_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        brust,
  input  logic [SIZE_W-1:0] size,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] next_addr,
  output logic              legal
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size;
    incr_addr = addr + step;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = addr;
    case (brust)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
    legal = (brust != BURST_RSVD) && (size <= 3'd2) &&
            ((brust != BURST_WRAP) || wrap_len_ok(len));
  end

endmodule

// File: rtl/ysyx_22050518_axi_sram_slave.sv
// AXI4 slave over an on-chip 32-bit word array with independent read and write FSMs.
// Handshake: a transfer happens on a rising edge where valid && ready; outputs are registered.
module ysyx_22050518_axi_sram_slave
  import ysyx_22050518_axi_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   axi_ar_id,
  input  logic [1:0]        axi_ar_brust,
  input  logic [LEN_W-1:0]  axi_ar_len,
  input  logic [SIZE_W-1:0] axi_ar_size,
  input  logic [ADDR_W-1:0] axi_ar_addr,
  input  logic              axi_ar_valid,
  output logic              axi_ar_ready,
  output logic [DATA_W-1:0] axi_r_data,
  output logic              axi_r_valid,
  input  logic              axi_r_ready,
  output logic [ID_W-1:0]   axi_r_id,
  output logic              axi_r_last,
  output logic [1:0]        axi_r_resp,
  input  logic [ID_W-1:0]   axi_aw_id,
  input  logic [1:0]        axi_aw_brust,
  input  logic [LEN_W-1:0]  axi_aw_len,
  input  logic [SIZE_W-1:0] axi_aw_size,
  input  logic [ADDR_W-1:0] axi_aw_addr,
  input  logic              axi_aw_valid,
  output logic              axi_aw_ready,
  input  logic [DATA_W-1:0] axi_w_data,
  input  logic              axi_w_valid,
  output logic              axi_w_ready,
  input  logic              axi_w_last,
  input  logic [STRB_W-1:0] axi_w_strb,
  input  logic              axi_b_ready,
  output logic              axi_b_valid,
  output logic [1:0]        axi_b_resp,
  output logic [ID_W-1:0]   axi_b_id
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd4;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && (a < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read path ----------------
  r_state_e          r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [1:0]        r_brust;
  logic [SIZE_W-1:0] r_size;
  logic              ar_hs, r_hs;
  logic [ADDR_W-1:0] rd_src_addr, rd_next_addr, rd_beat_addr;
  logic [1:0]        rd_src_brust;
  logic [SIZE_W-1:0] rd_src_size;
  logic [LEN_W-1:0]  rd_src_len;
  logic              rd_legal, rd_ok;
  logic [DATA_W-1:0] rd_word;

  assign ar_hs = axi_ar_valid && axi_ar_ready;
  assign r_hs  = axi_r_valid && axi_r_ready;

  // In idle the helper sees the incoming AR so beat 0 gets the right legality.
  always_comb begin
    rd_src_addr  = (r_state == R_IDLE) ? axi_ar_addr  : r_addr;
    rd_src_brust = (r_state == R_IDLE) ? axi_ar_brust : r_brust;
    rd_src_size  = (r_state == R_IDLE) ? axi_ar_size  : r_size;
    rd_src_len   = (r_state == R_IDLE) ? axi_ar_len   : r_len;
    rd_beat_addr = (r_state == R_IDLE) ? axi_ar_addr  : rd_next_addr;
    rd_ok        = rd_legal && in_range(rd_beat_addr);
    rd_word      = rd_ok ? mem[word_idx(rd_beat_addr)] : '0;
  end

  ysyx_22050518_axi_burst_addr u_rd_addr (
    .addr      (rd_src_addr),
    .brust     (rd_src_brust),
    .size      (rd_src_size),
    .len       (rd_src_len),
    .next_addr (rd_next_addr),
    .legal     (rd_legal)
  );

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && axi_r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      axi_ar_ready <= 1'b0;
      axi_r_valid  <= 1'b0;
      axi_r_data   <= '0;
      axi_r_last   <= 1'b0;
      axi_r_resp   <= RESP_OKAY;
      axi_r_id     <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_brust      <= '0;
      r_size       <= '0;
    end else begin
      r_state      <= r_state_nxt;
      axi_ar_ready <= (r_state_nxt == R_IDLE);
      axi_r_valid  <= (r_state_nxt == R_DATA);
      if (ar_hs) begin
        axi_r_id   <= axi_ar_id;
        r_addr     <= axi_ar_addr;
        r_len      <= axi_ar_len;
        r_brust    <= axi_ar_brust;
        r_size     <= axi_ar_size;
        r_cnt      <= '0;
        axi_r_data <= rd_word;
        axi_r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        axi_r_last <= (axi_ar_len == '0);
      end else if (r_hs && !axi_r_last) begin
        r_addr     <= rd_next_addr;
        r_cnt      <= r_cnt + 8'd1;
        axi_r_data <= rd_word;
        axi_r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        axi_r_last <= ((r_cnt + 8'd1) == r_len);
      end else if (r_hs) begin
        axi_r_last <= 1'b0;
      end
    end
  end

  // ---------------- write path ----------------
  w_state_e          w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr, wr_next_addr;
  logic [LEN_W-1:0]  w_len, w_cnt;
  logic [1:0]        w_brust;
  logic [SIZE_W-1:0] w_size;
  logic              w_err, w_overrun;
  logic              aw_hs, w_hs, b_hs;
  logic              wr_legal, wr_ok, wr_bad_last, wr_err_any;

  assign aw_hs = axi_aw_valid && axi_aw_ready;
  assign w_hs  = axi_w_valid && axi_w_ready;
  assign b_hs  = axi_b_valid && axi_b_ready;

  ysyx_22050518_axi_burst_addr u_wr_addr (
    .addr      (w_addr),
    .brust     (w_brust),
    .size      (w_size),
    .len       (w_len),
    .next_addr (wr_next_addr),
    .legal     (wr_legal)
  );

  // Beats past len are dropped; w_overrun remembers we already consumed beat len.
  assign wr_ok       = wr_legal && in_range(w_addr) && !w_overrun;
  assign wr_bad_last = axi_w_last && (w_overrun || (w_cnt != w_len));
  assign wr_err_any  = w_err || !wr_ok || wr_bad_last;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && axi_w_last) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      axi_aw_ready <= 1'b0;
      axi_w_ready  <= 1'b0;
      axi_b_valid  <= 1'b0;
      axi_b_resp   <= RESP_OKAY;
      axi_b_id     <= '0;
      w_addr       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_brust      <= '0;
      w_size       <= '0;
      w_err        <= 1'b0;
      w_overrun    <= 1'b0;
    end else begin
      w_state      <= w_state_nxt;
      axi_aw_ready <= (w_state_nxt == W_IDLE);
      axi_w_ready  <= (w_state_nxt == W_DATA);
      axi_b_valid  <= (w_state_nxt == W_RESP);
      if (aw_hs) begin
        axi_b_id  <= axi_aw_id;
        w_addr    <= axi_aw_addr;
        w_len     <= axi_aw_len;
        w_brust   <= axi_aw_brust;
        w_size    <= axi_aw_size;
        w_cnt     <= '0;
        w_err     <= 1'b0;
        w_overrun <= 1'b0;
      end else if (w_hs) begin
        w_addr <= wr_next_addr;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= wr_err_any;
        if ((w_cnt == w_len) && !axi_w_last) w_overrun <= 1'b1;
        if (axi_w_last) axi_b_resp <= wr_err_any ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_hs && wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_w_strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050518_axi_sram_slave.sv
// Directed bench for the AXI SRAM slave: table of read bursts plus hand-written
// write, strobe, error, concurrency and reset-mid-burst sequences.
module tb_ysyx_22050518_axi_sram_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk, rst_n;
  logic [3:0]  axi_ar_id;
  logic [1:0]  axi_ar_brust;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [63:0] axi_ar_addr;
  logic        axi_ar_valid, axi_ar_ready;
  logic [31:0] axi_r_data;
  logic        axi_r_valid, axi_r_ready, axi_r_last;
  logic [3:0]  axi_r_id;
  logic [1:0]  axi_r_resp;
  logic [3:0]  axi_aw_id;
  logic [1:0]  axi_aw_brust;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size;
  logic [63:0] axi_aw_addr;
  logic        axi_aw_valid, axi_aw_ready;
  logic [31:0] axi_w_data;
  logic        axi_w_valid, axi_w_ready, axi_w_last;
  logic [3:0]  axi_w_strb;
  logic        axi_b_ready, axi_b_valid;
  logic [1:0]  axi_b_resp;
  logic [3:0]  axi_b_id;

  ysyx_22050518_axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_ar_id(axi_ar_id), .axi_ar_brust(axi_ar_brust), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_id(axi_r_id), .axi_r_last(axi_r_last), .axi_r_resp(axi_r_resp),
    .axi_aw_id(axi_aw_id), .axi_aw_brust(axi_aw_brust), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_last(axi_w_last), .axi_w_strb(axi_w_strb),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
    .axi_b_id(axi_b_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;

  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];
  int          rd_last_idx, rd_lat, rd_cycles, rd_id_err, rd_stall_err;

  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic        wq_last[$];
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  int          wr_bwait;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] brust, input logic [2:0] size, input bit toggle);
    int k;
    bit got_last, stalled;
    logic [31:0] held;
    rd_data_q.delete();
    rd_resp_q.delete();
    rd_last_idx = -1; rd_lat = -1; rd_id_err = 0; rd_stall_err = 0;
    axi_ar_id = id; axi_ar_addr = addr; axi_ar_len = len;
    axi_ar_brust = brust; axi_ar_size = size; axi_ar_valid = 1'b1;
    k = 0;
    while (!axi_ar_ready && k < 50) begin @(negedge clk); k++; end
    check("ar_accept", k < 50, 1'b1);
    @(negedge clk);
    axi_ar_valid = 1'b0;
    got_last = 0; stalled = 0; held = '0; k = 0;
    while (!got_last && k < 2000) begin
      axi_r_ready = toggle ? ((k % 2) == 0) : 1'b1;
      if (axi_r_valid) begin
        if (rd_lat < 0) rd_lat = k;
        if (stalled && (axi_r_data !== held)) rd_stall_err++;
        if (axi_r_id !== id) rd_id_err++;
        if (axi_r_ready) begin
          rd_data_q.push_back(axi_r_data);
          rd_resp_q.push_back(axi_r_resp);
          if (axi_r_last) begin rd_last_idx = rd_data_q.size() - 1; got_last = 1; end
          stalled = 0;
        end else begin
          stalled = 1; held = axi_r_data;
        end
      end
      @(negedge clk);
      k++;
    end
    rd_cycles = k;
    axi_r_ready = 1'b1;
    check("r_last_seen", got_last, 1'b1);
  endtask

  task automatic wpush(input logic [31:0] d, input logic [3:0] s, input logic l);
    wq_data.push_back(d); wq_strb.push_back(s); wq_last.push_back(l);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] brust, input logic [2:0] size);
    int k;
    axi_aw_id = id; axi_aw_addr = addr; axi_aw_len = len;
    axi_aw_brust = brust; axi_aw_size = size; axi_aw_valid = 1'b1;
    k = 0;
    while (!axi_aw_ready && k < 50) begin @(negedge clk); k++; end
    check("aw_accept", k < 50, 1'b1);
    @(negedge clk);
    axi_aw_valid = 1'b0;
    for (int i = 0; i < wq_data.size(); i++) begin
      axi_w_data = wq_data[i]; axi_w_strb = wq_strb[i]; axi_w_last = wq_last[i];
      axi_w_valid = 1'b1;
      k = 0;
      while (!axi_w_ready && k < 50) begin @(negedge clk); k++; end
      check("w_accept", k < 50, 1'b1);
      @(negedge clk);
    end
    axi_w_valid = 1'b0; axi_w_last = 1'b0;
    k = 0;
    while (!axi_b_valid && k < 50) begin @(negedge clk); k++; end
    check("b_seen", k < 50, 1'b1);
    wr_bwait = k; wr_resp = axi_b_resp; wr_bid = axi_b_id;
    @(negedge clk);
    wq_data.delete(); wq_strb.delete(); wq_last.delete();
  endtask

  // ---------------- read vector table ----------------
  typedef struct packed {
    logic [3:0]   id;
    logic [1:0]   brust;
    logic [2:0]   size;
    logic [7:0]   len;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [7:0]   resp;
  } rd_vec_t;

  function automatic rd_vec_t mkv(input logic [3:0] id, input logic [1:0] brust,
                                  input logic [2:0] size, input logic [7:0] len,
                                  input logic [63:0] addr,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3,
                                  input logic [7:0] resp);
    rd_vec_t v;
    v.id = id; v.brust = brust; v.size = size; v.len = len; v.addr = addr;
    v.data = {d3, d2, d1, d0}; v.resp = resp;
    return v;
  endfunction

  localparam int NV = 10;
  rd_vec_t vecs [NV];

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    axi_ar_id = '0; axi_ar_brust = '0; axi_ar_len = '0; axi_ar_size = '0; axi_ar_addr = '0;
    axi_ar_valid = 1'b0; axi_r_ready = 1'b1;
    axi_aw_id = '0; axi_aw_brust = '0; axi_aw_len = '0; axi_aw_size = '0; axi_aw_addr = '0;
    axi_aw_valid = 1'b0; axi_w_data = '0; axi_w_valid = 1'b0; axi_w_last = 1'b0;
    axi_w_strb = 4'hF; axi_b_ready = 1'b1;

    // Expected contents after setup: 0..3 = C,D,A,B from the WRAP write, 4..15 = A5A5_00nn.
    vecs[0] = mkv(4'd1, 2'b01, 3'd2, 8'd3, BASE + 64'h10,
                  32'hA5A5_0004, 32'hA5A5_0005, 32'hA5A5_0006, 32'hA5A5_0007, 8'h00);
    vecs[1] = mkv(4'd3, 2'b10, 3'd2, 8'd3, BASE + 64'h08,
                  32'hC0DE_000A, 32'hC0DE_000B, 32'hC0DE_000C, 32'hC0DE_000D, 8'h00);
    vecs[2] = mkv(4'd4, 2'b00, 3'd2, 8'd2, BASE + 64'h18,
                  32'hA5A5_0006, 32'hA5A5_0006, 32'hA5A5_0006, 32'h0, 8'h00);
    vecs[3] = mkv(4'd5, 2'b01, 3'd2, 8'd1, BASE + 64'h1000,
                  32'h0, 32'h0, 32'h0, 32'h0, 8'b0000_1010);
    vecs[4] = mkv(4'd6, 2'b11, 3'd2, 8'd0, BASE,
                  32'h0, 32'h0, 32'h0, 32'h0, 8'b0000_0010);
    vecs[5] = mkv(4'd7, 2'b01, 3'd3, 8'd0, BASE + 64'h20,
                  32'h0, 32'h0, 32'h0, 32'h0, 8'b0000_0010);
    vecs[6] = mkv(4'd8, 2'b10, 3'd2, 8'd2, BASE,
                  32'h0, 32'h0, 32'h0, 32'h0, 8'b0010_1010);
    vecs[7] = mkv(4'd9, 2'b01, 3'd0, 8'd1, BASE + 64'h21,
                  32'hA5A5_0008, 32'hA5A5_0008, 32'h0, 32'h0, 8'h00);
    vecs[8] = mkv(4'd10, 2'b01, 3'd2, 8'd1, BASE - 64'd4,
                  32'h0, 32'hC0DE_000C, 32'h0, 32'h0, 8'b0000_0010);
    vecs[9] = mkv(4'd11, 2'b10, 3'd2, 8'd1, BASE + 64'h14,
                  32'hA5A5_0005, 32'hA5A5_0004, 32'h0, 32'h0, 8'h00);

    // Reset values, then readies one edge after release.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {axi_ar_ready, axi_aw_ready, axi_w_ready, axi_r_valid, axi_b_valid,
           axi_r_last, axi_r_resp, axi_b_resp, axi_r_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {axi_ar_ready, axi_aw_ready, axi_w_ready}, 3'b110);

    // Fill words 0..15.
    for (int i = 0; i < 16; i++) wpush(32'hA5A5_0000 | 32'(i), 4'hF, i == 15);
    do_write(4'd2, BASE, 8'd15, 2'b01, 3'd2);
    check("fill_b_resp", wr_resp, 2'b00);
    check("fill_b_id", wr_bid, 4'd2);
    check("fill_b_latency", wr_bwait, 0);
    check("aw_ready_after_b", axi_aw_ready, 1'b1);

    // WRAP write: beats land on words 2,3,0,1.
    wpush(32'hC0DE_000A, 4'hF, 1'b0); wpush(32'hC0DE_000B, 4'hF, 1'b0);
    wpush(32'hC0DE_000C, 4'hF, 1'b0); wpush(32'hC0DE_000D, 4'hF, 1'b1);
    do_write(4'd3, BASE + 64'h08, 8'd3, 2'b10, 3'd2);
    check("wrap_b_resp", wr_resp, 2'b00);

    for (int v = 0; v < NV; v++) begin
      do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].brust, vecs[v].size, 1'b0);
      check($sformatf("v%0d_beats", v), rd_data_q.size(), int'(vecs[v].len) + 1);
      check($sformatf("v%0d_last_idx", v), rd_last_idx, int'(vecs[v].len));
      check($sformatf("v%0d_r_id", v), rd_id_err, 0);
      check($sformatf("v%0d_latency", v), rd_lat, 0);
      check($sformatf("v%0d_cycles", v), rd_cycles, int'(vecs[v].len) + 1);
      for (int b = 0; b < rd_data_q.size() && b < 4; b++) begin
        check($sformatf("v%0d_data%0d", v, b), rd_data_q[b], vecs[v].data[32*b +: 32]);
        check($sformatf("v%0d_resp%0d", v, b), rd_resp_q[b], vecs[v].resp[2*b +: 2]);
      end
    end

    // Strobed FIXED write over word 1 (was C0DE_000D).
    wpush(32'h0000_0011, 4'b0001, 1'b0); wpush(32'h4400_0000, 4'b1000, 1'b1);
    do_write(4'd5, BASE + 64'h4, 8'd1, 2'b00, 3'd2);
    check("strb_b_resp", wr_resp, 2'b00);
    check("strb_b_id", wr_bid, 4'd5);
    do_read(4'd15, BASE + 64'h4, 8'd0, 2'b01, 3'd2, 1'b0);
    check("strb_word1", rd_data_q[0], 32'h44DE_0011);

    // Early w_last on beat 1 of a 4-beat burst.
    wpush(32'h1111_0000, 4'hF, 1'b0); wpush(32'h2222_0000, 4'hF, 1'b1);
    do_write(4'd6, BASE + 64'h40, 8'd3, 2'b01, 3'd2);
    check("early_last_b_resp", wr_resp, 2'b10);
    check("early_last_b_id", wr_bid, 4'd6);

    // Extra beat past len: second beat dropped, word 18 keeps the first.
    wpush(32'h3333_0000, 4'hF, 1'b0); wpush(32'h4444_0000, 4'hF, 1'b1);
    do_write(4'd9, BASE + 64'h48, 8'd0, 2'b00, 3'd2);
    check("overrun_b_resp", wr_resp, 2'b10);
    do_read(4'd1, BASE + 64'h48, 8'd0, 2'b01, 3'd2, 1'b0);
    check("overrun_word18", rd_data_q[0], 32'h3333_0000);

    // Out-of-range write must not alias onto word 0.
    wpush(32'hBAD0_0000, 4'hF, 1'b1);
    do_write(4'd10, BASE + 64'h1000, 8'd0, 2'b01, 3'd2);
    check("oor_b_resp", wr_resp, 2'b10);

    // 8-beat read with 1010 backpressure while a 4-beat write runs.
    for (int i = 0; i < 4; i++) wpush(32'h5000_0000 | 32'(i), 4'hF, i == 3);
    fork
      do_read(4'd7, BASE, 8'd7, 2'b01, 3'd2, 1'b1);
      do_write(4'd8, BASE + 64'h80, 8'd3, 2'b01, 3'd2);
    join
    check("conc_b_resp", wr_resp, 2'b00);
    check("conc_b_id", wr_bid, 4'd8);
    check("conc_r_beats", rd_data_q.size(), 8);
    check("conc_r_id", rd_id_err, 0);
    check("conc_r_stable", rd_stall_err, 0);
    check("conc_r_last_idx", rd_last_idx, 7);
    if (rd_data_q.size() == 8) begin
      check("conc_r0", rd_data_q[0], 32'hC0DE_000C);
      check("conc_r1", rd_data_q[1], 32'h44DE_0011);
      check("conc_r2", rd_data_q[2], 32'hC0DE_000A);
      check("conc_r3", rd_data_q[3], 32'hC0DE_000B);
      check("conc_r7", rd_data_q[7], 32'hA5A5_0007);
    end
    do_read(4'd2, BASE + 64'h80, 8'd3, 2'b01, 3'd2, 1'b0);
    for (int b = 0; b < rd_data_q.size(); b++)
      check($sformatf("conc_wb%0d", b), rd_data_q[b], 32'h5000_0000 | 32'(b));

    // Longest burst: 256 FIXED beats, counter must not overflow.
    begin
      int bad = 0;
      do_read(4'd11, BASE + 64'h10, 8'd255, 2'b00, 3'd2, 1'b0);
      foreach (rd_data_q[i]) if (rd_data_q[i] !== 32'hA5A5_0004) bad++;
      check("len255_beats", rd_data_q.size(), 256);
      check("len255_last_idx", rd_last_idx, 255);
      check("len255_bad_data", bad, 0);
    end

    // Simultaneous AR/AW, then reset during beat 2 of 4.
    axi_ar_id = 4'd12; axi_ar_addr = BASE + 64'hC0; axi_ar_len = 8'd3;
    axi_ar_brust = 2'b01; axi_ar_size = 3'd2; axi_ar_valid = 1'b1;
    axi_aw_id = 4'd13; axi_aw_addr = BASE + 64'hC0; axi_aw_len = 8'd3;
    axi_aw_brust = 2'b01; axi_aw_size = 3'd2; axi_aw_valid = 1'b1;
    check("dual_ready", {axi_ar_ready, axi_aw_ready}, 2'b11);
    @(negedge clk);
    axi_ar_valid = 1'b0; axi_aw_valid = 1'b0;
    check("dual_accept", {axi_r_valid, axi_w_ready}, 2'b11);
    axi_r_ready = 1'b1;
    axi_w_data = 32'h600D_0000; axi_w_strb = 4'hF; axi_w_last = 1'b0; axi_w_valid = 1'b1;
    @(negedge clk);
    axi_w_data = 32'h600D_0001;
    @(negedge clk);
    check("beat2_pending", {axi_r_valid, axi_w_ready}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_drop", {axi_r_valid, axi_w_ready, axi_ar_ready, axi_aw_ready, axi_b_valid}, '0);
    axi_w_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", {axi_ar_ready, axi_aw_ready}, 2'b11);
    do_read(4'd14, BASE + 64'hC0, 8'd1, 2'b01, 3'd2, 1'b0);
    check("post_reset_beats", rd_data_q.size(), 2);
    if (rd_data_q.size() == 2) begin
      check("post_reset_d0", rd_data_q[0], 32'h600D_0000);
      check("post_reset_d1", rd_data_q[1], 32'h600D_0001);
      check("post_reset_resp", {rd_resp_q[0], rd_resp_q[1]}, 4'b0000);
    end
    wpush(32'h7777_0000, 4'hF, 1'b1);
    do_write(4'd15, BASE + 64'hD0, 8'd0, 2'b01, 3'd2);
    check("post_reset_b_resp", wr_resp, 2'b00);
    check("post_reset_b_id", wr_bid, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
